branch_resolve: RTL and testbench

Branch resolution unit in the ID stage; it drives the branch controls that the fetch stage consumes to choose the next PC. It decodes the 16-bit instruction in IF/ID, evaluates conditions against a local flags register, and holds off on flag or register hazards. After a taken branch it flushes the wrong-path instructions and issues the link-register write for BL. It also keeps a saturating count of taken branches for performance counting.

---
 rtl/branch_resolve_pkg.sv | 35 +++
 rtl/cond_eval.sv | 26 ++
 rtl/d_flip_flop.sv | 20 ++
 rtl/branch_resolve.sv | 156 +++++++++++++++
 tb/tb_branch_resolve.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared opcodes, branch types, condition codes and flag indices
package branch_resolve_pkg;

    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_B     = 4'hD;
    localparam logic [3:0] OP_BL    = 4'hE;
    localparam logic [3:0] OP_BR    = 4'hF;

    localparam logic [1:0] BT_COND   = 2'd0;
    localparam logic [1:0] BT_UNCOND = 2'd1;
    localparam logic [1:0] BT_LINK   = 2'd2;
    localparam logic [1:0] BT_REG    = 2'd3;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_LT = 4'd2;
    localparam logic [3:0] CC_GE = 4'd3;
    localparam logic [3:0] CC_CS = 4'd4;
    localparam logic [3:0] CC_CC = 4'd5;
    localparam logic [3:0] CC_MI = 4'd6;
    localparam logic [3:0] CC_AL = 4'd7;

    // Flags are packed {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - condition code evaluation against {N,Z,C,V}
module cond_eval
    import branch_resolve_pkg::*;
(
    input  logic [3:0] cond_code,
    input  logic [3:0] flags,
    output logic       cond_true
);

    // Codes 8-15 are reserved and never satisfied
    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            CC_EQ:   cond_true = flags[FLAG_Z];
            CC_NE:   cond_true = ~flags[FLAG_Z];
            CC_LT:   cond_true = flags[FLAG_N] ^ flags[FLAG_V];
            CC_GE:   cond_true = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            CC_CS:   cond_true = flags[FLAG_C];
            CC_CC:   cond_true = ~flags[FLAG_C];
            CC_MI:   cond_true = flags[FLAG_N];
            CC_AL:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - generic register with synchronous active-high clear
module d_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Plain D register, cleared to zero by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - ID-stage branch decode, hazard stall, flush and link write
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int         FLUSH_CYCLES = 1,
    parameter logic [3:0] LINK_REG     = 4'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic [3:0]  alu_flags,
    input  logic        flags_we,
    input  logic        reg_busy,
    input  logic [15:0] link_pc,
    output logic [1:0]  branch_type,
    output logic        BrTaken,
    output logic        reg_branch,
    output logic [7:0]  cond_address,
    output logic [10:0] uncond_address,
    output logic [5:0]  link_address,
    output logic        stall,
    output logic        flush,
    output logic        link_we,
    output logic [3:0]  link_waddr,
    output logic [15:0] link_wdata,
    output logic [15:0] taken_count
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        link_we_q, link_we_d;
    logic [15:0] taken_count_q, taken_count_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] link_wdata_q, link_wdata_d;
    logic        cond_true, branch_rule, taken;

    logic [3:0] opcode;
    logic       is_bcond, is_b, is_bl, is_br;

    assign opcode   = instr[15:12];
    assign is_bcond = (opcode == OP_BCOND);
    assign is_b     = (opcode == OP_B);
    assign is_bl    = (opcode == OP_BL);
    assign is_br    = (opcode == OP_BR);

    // Flags follow EX writes in every state, including HOLD and FLUSH
    assign flags_d = flags_we ? alu_flags : flags_q;
    d_flip_flop #(.WIDTH(4)) u_flags_ff (
        .clk   (clk),
        .reset (reset),
        .d     (flags_d),
        .q     (flags_q)
    );

    cond_eval u_cond_eval (
        .cond_code (instr[11:8]),
        .flags     (flags_q),
        .cond_true (cond_true)
    );

    assign branch_rule = instr_valid & (is_b | is_bl | is_br | (is_bcond & cond_true));

    // Next-state and take/stall decision; flags hazard parks in HOLD, register hazard stalls in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        taken   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && is_bcond && flags_we) begin
                    stall   = 1'b1;
                    state_d = ST_HOLD;
                end else if (instr_valid && is_br && reg_busy) begin
                    stall = 1'b1;
                end else begin
                    taken = branch_rule;
                end
            end
            ST_HOLD: begin
                taken   = branch_rule;
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (taken) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
        end
        if (reset) begin
            taken = 1'b0;
            stall = 1'b0;
        end
    end

    // Link strobe, captured return address and saturating taken counter
    always_comb begin
        link_we_d     = taken & is_bl;
        link_wdata_d  = (taken && is_bl) ? link_pc : link_wdata_q;
        taken_count_d = taken_count_q;
        if (taken && (taken_count_q != 16'hFFFF)) begin
            taken_count_d = taken_count_q + 16'd1;
        end
    end

    d_flip_flop #(.WIDTH(16)) u_link_wdata_ff (
        .clk   (clk),
        .reset (reset),
        .d     (link_wdata_d),
        .q     (link_wdata_q)
    );

    // State, flush counter, link strobe and taken counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            link_we_q     <= 1'b0;
            taken_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            link_we_q     <= link_we_d;
            taken_count_q <= taken_count_d;
        end
    end

    // Branch class seen by fetch; non-branches report the conditional encoding
    always_comb begin
        branch_type = BT_COND;
        if (is_b)  branch_type = BT_UNCOND;
        if (is_bl) branch_type = BT_LINK;
        if (is_br) branch_type = BT_REG;
    end

    assign BrTaken        = taken;
    assign reg_branch     = is_br;
    assign cond_address   = instr[7:0];
    assign uncond_address = instr[10:0];
    assign link_address   = instr[5:0];
    assign flush          = (state_q == ST_FLUSH);
    assign link_we        = link_we_q;
    assign link_waddr     = LINK_REG;
    assign link_wdata     = link_wdata_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve with FLUSH_CYCLES of 1 and 3
module tb_branch_resolve;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  alu_flags;
    logic        flags_we;
    logic        reg_busy;
    logic [15:0] link_pc;

    logic [1:0]  bt    [2];
    logic        tkn   [2];
    logic        regb  [2];
    logic [7:0]  ca    [2];
    logic [10:0] ua    [2];
    logic [5:0]  la    [2];
    logic        stl   [2];
    logic        fls   [2];
    logic        lwe   [2];
    logic [3:0]  lwa   [2];
    logic [15:0] lwd   [2];
    logic [15:0] tc    [2];

    int vectors;
    int miscompares;

    int          fcs     [2];
    int          m_left  [2];
    bit          m_hold  [2];
    logic [3:0]  m_flags [2];
    bit          m_lwe   [2];
    logic [15:0] m_lwd   [2];
    int          m_cnt   [2];

    branch_resolve #(.FLUSH_CYCLES(1), .LINK_REG(4'd15)) dut1 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .alu_flags(alu_flags), .flags_we(flags_we), .reg_busy(reg_busy), .link_pc(link_pc),
        .branch_type(bt[0]), .BrTaken(tkn[0]), .reg_branch(regb[0]),
        .cond_address(ca[0]), .uncond_address(ua[0]), .link_address(la[0]),
        .stall(stl[0]), .flush(fls[0]), .link_we(lwe[0]), .link_waddr(lwa[0]),
        .link_wdata(lwd[0]), .taken_count(tc[0])
    );

    branch_resolve #(.FLUSH_CYCLES(3), .LINK_REG(4'd15)) dut3 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .alu_flags(alu_flags), .flags_we(flags_we), .reg_busy(reg_busy), .link_pc(link_pc),
        .branch_type(bt[1]), .BrTaken(tkn[1]), .reg_branch(regb[1]),
        .cond_address(ca[1]), .uncond_address(ua[1]), .link_address(la[1]),
        .stall(stl[1]), .flush(fls[1]), .link_we(lwe[1]), .link_waddr(lwa[1]),
        .link_wdata(lwd[1]), .taken_count(tc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'd0: return z;
            4'd1: return !z;
            4'd2: return n ^ v;
            4'd3: return !(n ^ v);
            4'd4: return c;
            4'd5: return !c;
            4'd6: return n;
            4'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (FLUSH_CYCLES=%0d): observed %h expected %h", tag, fcs[k], obs, exp);
        end
    endtask

    // One clock: check both instances at the falling edge, then advance the model
    task automatic step(input bit check_all);
        logic [3:0] op;
        bit ib, ibl, ibr, ibc, rule, t, s;
        logic [1:0] ebt;
        op  = instr[15:12];
        ibc = (op == 4'hC);
        ib  = (op == 4'hD);
        ibl = (op == 4'hE);
        ibr = (op == 4'hF);
        ebt = ib ? 2'd1 : ibl ? 2'd2 : ibr ? 2'd3 : 2'd0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rule = instr_valid && (ib || ibl || ibr || (ibc && cond_ok(instr[11:8], m_flags[k])));
            t = 1'b0;
            s = 1'b0;
            if (!reset && m_left[k] == 0) begin
                if (m_hold[k])                          t = rule;
                else if (instr_valid && ibc && flags_we) s = 1'b1;
                else if (instr_valid && ibr && reg_busy) s = 1'b1;
                else                                    t = rule;
            end
            chk("BrTaken", k, 16'(tkn[k]), 16'(t));
            chk("stall", k, 16'(stl[k]), 16'(s));
            chk("flush", k, 16'(fls[k]), 16'(m_left[k] > 0));
            chk("taken_count", k, tc[k], 16'(m_cnt[k]));
            if (check_all) begin
                chk("branch_type", k, 16'(bt[k]), 16'(ebt));
                chk("reg_branch", k, 16'(regb[k]), 16'(ibr));
                chk("cond_address", k, 16'(ca[k]), {8'h00, instr[7:0]});
                chk("uncond_address", k, 16'(ua[k]), {5'h00, instr[10:0]});
                chk("link_address", k, 16'(la[k]), {10'h000, instr[5:0]});
                chk("link_we", k, 16'(lwe[k]), 16'(m_lwe[k]));
                chk("link_waddr", k, 16'(lwa[k]), 16'd15);
                chk("link_wdata", k, lwd[k], m_lwd[k]);
            end
            if (reset) begin
                m_left[k]  = 0;
                m_hold[k]  = 1'b0;
                m_flags[k] = 4'h0;
                m_lwe[k]   = 1'b0;
                m_lwd[k]   = 16'h0;
                m_cnt[k]   = 0;
            end else begin
                if (m_left[k] > 0) m_left[k]--;
                else if (t)        m_left[k] = fcs[k];
                m_hold[k] = s && ibc;
                m_lwe[k]  = t && ibl;
                if (t && ibl) m_lwd[k] = link_pc;
                if (t && m_cnt[k] < 65535) m_cnt[k]++;
                if (flags_we) m_flags[k] = alu_flags;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        instr       = 16'h0000;
        instr_valid = 1'b0;
        flags_we    = 1'b0;
        reg_busy    = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fcs[0] = 1;
        fcs[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_hold[k] = 1'b0; m_flags[k] = 4'h0;
            m_lwe[k] = 1'b0; m_lwd[k] = 16'h0; m_cnt[k] = 0;
        end
        reset = 1'b1; instr = 16'h0; instr_valid = 1'b0; alu_flags = 4'h0;
        flags_we = 1'b0; reg_busy = 1'b0; link_pc = 16'h0;
        @(posedge clk);
        #1;
        step(1'b1);
        step(1'b1);
        reset = 1'b0;
        idle(1);

        // Unconditional branch
        instr = 16'hD005; instr_valid = 1'b1;
        step(1'b1);
        chk("b_flush_on", 0, 16'(fls[0]), 16'd1);
        chk("b_count", 0, tc[0], 16'd1);
        idle(1);
        chk("b_flush_off", 0, 16'(fls[0]), 16'd0);
        idle(3);

        // BEQ arriving with a flag write: stall, then decide on Z=1
        instr = 16'hC0FC; instr_valid = 1'b1; flags_we = 1'b1; alu_flags = 4'b0100;
        step(1'b1);
        flags_we = 1'b0;
        step(1'b1);
        chk("beq_flush", 0, 16'(fls[0]), 16'd1);
        idle(4);

        // BNE with Z=1 and reserved code 4'hA are never taken
        instr = 16'hC123; instr_valid = 1'b1;
        step(1'b1);
        chk("bne_no_flush", 0, 16'(fls[0]), 16'd0);
        instr = 16'hCA10; alu_flags = 4'hF; flags_we = 1'b1;
        step(1'b1);
        flags_we = 1'b0;
        step(1'b1);
        chk("cc_a_no_flush", 0, 16'(fls[0]), 16'd0);
        idle(1);

        // BL captures the return address
        instr = 16'hE003; instr_valid = 1'b1; link_pc = 16'h0041;
        step(1'b1);
        link_pc = 16'h1234;
        chk("bl_link_we", 0, 16'(lwe[0]), 16'd1);
        chk("bl_link_waddr", 0, 16'(lwa[0]), 16'd15);
        chk("bl_link_wdata", 0, lwd[0], 16'h0041);
        idle(4);

        // BR waits out a busy source register
        instr = 16'hF000; instr_valid = 1'b1; reg_busy = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        reg_busy = 1'b0;
        step(1'b1);
        idle(4);

        // Reset in the second flush cycle of the three-cycle instance
        instr = 16'hD001; instr_valid = 1'b1;
        step(1'b1);
        idle(1);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        chk("rst_mid_flush", 1, 16'(fls[1]), 16'd0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [3:0] op;
            r = int'($urandom_range(0, 5));
            op = (r < 4) ? 4'(12 + r) : 4'($urandom_range(0, 11));
            instr       = {op, 12'($urandom)};
            instr_valid = ($urandom_range(0, 9) != 0);
            flags_we    = ($urandom_range(0, 3) == 0);
            alu_flags   = 4'($urandom);
            reg_busy    = ($urandom_range(0, 2) == 0);
            link_pc     = 16'($urandom);
            reset       = ($urandom_range(0, 59) == 0);
            step(1'b1);
        end
        reset = 1'b0;

        // Saturation of the taken counter
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        instr = 16'hD000; instr_valid = 1'b1; flags_we = 1'b0; reg_busy = 1'b0;
        for (int i = 0; i < 131100; i++) step(1'b0);
        chk("sat_count", 0, tc[0], 16'hFFFF);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
